// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, frame length and default timing.
// Receiver and transmitter both import this package.
package ps2_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_RTS       = 3'd2;
  localparam logic [2:0] ST_SHIFT     = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

  localparam int DEF_INHIBIT_CYCLES = 5000;
  localparam int DEF_TIMEOUT_CYCLES = 1_000_000;

  localparam int CNT_W    = 20;
  localparam int BITCNT_W = 4;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between a requester and the PS/2 host transmitter.
interface ps2_host_tx_if;

  // A byte transfers on the clk edge where tx_valid && tx_ready are both high.
  // tx_ready never depends on tx_valid; tx_data must be stable while tx_valid waits.
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for the PS/2 clock and data pads plus a falling-edge pulse on the clock.
// Synchronizer flops reset to 1 (idle bus level) so reset never produces a spurious edge.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_s,
    output logic data_s,
    output logic fall
);

    logic [1:0] clk_ff;
    logic [1:0] data_ff;
    logic       clk_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_ff   <= 2'b11;
            data_ff  <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[0], ps2_clk};
            data_ff  <= {data_ff[0], ps2_data};
            clk_prev <= clk_ff[1];
        end
    end

    assign clk_s  = clk_ff[1];
    assign data_s = data_ff[1];
    assign fall   = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift out data/parity/stop on
// device clock falls, then check the device acknowledge before returning to idle.
module ps2_host_tx
  import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    ps2_host_tx_if.slave    tx,
    input  logic            ps2_clk,
    input  logic            ps2_data,
    output logic            ps2_clk_oe,
    output logic            ps2_data_oe,
    output logic            busy,
    output logic            done,
    output logic            ack_err,
    output logic            timeout,
    output logic [2:0]      state_dbg
);

    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]    INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]    TMO_LIMIT  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [BITCNT_W-1:0] LAST_SHIFT = BITCNT_W'(FRAME_BITS - 2);

    logic [2:0]          state;
    logic [9:0]          shift;
    logic [BITCNT_W-1:0] bitcnt;
    logic [CNT_W-1:0]    cnt;
    logic                ack_ok;

    logic clk_s;
    logic data_s;
    logic fall;
    logic accept;
    logic in_frame;
    logic tmo_hit;

    ps2_sync_edge u_sync (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .clk_s    (clk_s),
        .data_s   (data_s),
        .fall     (fall)
    );

    assign tx.tx_ready = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign state_dbg   = state;
    assign accept      = tx.tx_valid & tx.tx_ready;

    // Device-clocked phases share one watchdog that restarts on every device clock fall.
    assign in_frame = (state == ST_RTS) || (state == ST_SHIFT) ||
                      (state == ST_ACK) || (state == ST_WAIT_IDLE);
    assign tmo_hit  = in_frame && (cnt == TMO_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            shift       <= '0;
            bitcnt      <= '0;
            cnt         <= '0;
            ack_ok      <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            ack_err     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            done    <= 1'b0;
            ack_err <= 1'b0;
            timeout <= 1'b0;

            if (tmo_hit) begin
                state       <= ST_IDLE;
                cnt         <= '0;
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                timeout     <= 1'b1;
            end else begin
                if (in_frame) begin
                    cnt <= fall ? '0 : cnt + CNT_ONE;
                end

                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            shift      <= {1'b1, odd_parity(tx.tx_data), tx.tx_data};
                            cnt        <= '0;
                            bitcnt     <= '0;
                            ps2_clk_oe <= 1'b1;
                            state      <= ST_INHIBIT;
                        end
                    end

                    ST_INHIBIT: begin
                        // Start bit goes out together with the clock release.
                        if (cnt == INH_LAST) begin
                            cnt         <= '0;
                            ps2_clk_oe  <= 1'b0;
                            ps2_data_oe <= 1'b1;
                            state       <= ST_RTS;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    ST_RTS: begin
                        if (fall) begin
                            ps2_data_oe <= ~shift[0];
                            shift       <= shift >> 1;
                            bitcnt      <= BITCNT_W'(1);
                            state       <= ST_SHIFT;
                        end
                    end

                    ST_SHIFT: begin
                        // shift[0] is always the bit for the edge numbered bitcnt+1.
                        if (fall) begin
                            ps2_data_oe <= ~shift[0];
                            shift       <= shift >> 1;
                            bitcnt      <= bitcnt + BITCNT_W'(1);
                            if (bitcnt == LAST_SHIFT) begin
                                state <= ST_ACK;
                            end
                        end
                    end

                    ST_ACK: begin
                        if (fall) begin
                            ack_ok <= ~data_s;
                            state  <= ST_WAIT_IDLE;
                        end
                    end

                    ST_WAIT_IDLE: begin
                        if (clk_s && data_s) begin
                            done    <= ack_ok;
                            ack_err <= ~ack_ok;
                            state   <= ST_IDLE;
                        end
                    end

                    default: begin
                        state       <= ST_IDLE;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device drives the open-drain lines and records the
// bits it samples; each scenario compares against frames computed from the byte and odd parity.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH    = 40;
  localparam int TMO    = 1500;
  localparam int HALF   = 16;
  localparam int PERIOD = 10;

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout;
  logic [2:0] state_dbg;
  logic       dev_clk;
  logic       dev_data;

  int n_vec  = 0;
  int n_miss = 0;

  int   done_seen      = 0;
  int   nack_seen      = 0;
  int   tmo_seen       = 0;
  int   inh_run        = 0;
  int   inh_len        = 0;
  logic ready_at_pulse = 1'b0;

  logic [9:0] exp_q[$];

  ps2_host_tx_if tx_if();

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx          (tx_if),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .ack_err     (ack_err),
    .timeout     (timeout),
    .state_dbg   (state_dbg)
  );

  // Wired-AND open-drain bus: either side can pull a line low.
  assign ps2_clk  = dev_clk & ~ps2_clk_oe;
  assign ps2_data = dev_data & ~ps2_data_oe;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #(PERIOD / 2) clk = ~clk;
  end

  initial begin
    #(PERIOD * 90000);
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  // Pulse counters and inhibit-length measurement.
  always @(negedge clk) begin
    if (done) done_seen++;
    if (ack_err) nack_seen++;
    if (timeout) tmo_seen++;
    if (done || ack_err) ready_at_pulse = tx_if.tx_ready;
    if (ps2_clk_oe === 1'b1) inh_run++;
    else if (inh_run != 0) begin
      inh_len = inh_run;
      inh_run = 0;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [9:0] model_frame(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
  endfunction

  // ---------------- drivers ----------------
  task automatic send_start(input logic [7:0] b);
    @(negedge clk);
    tx_if.tx_data  = b;
    tx_if.tx_valid = 1'b1;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
  endtask

  task automatic device_clock(input int n_edges, input bit ack_low,
                              output logic [9:0] seen, output bit start_low, output time t_fall);
    int guard;
    seen      = '0;
    start_low = 1'b0;
    t_fall    = 0;
    guard     = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && guard < INH + 100) begin
      @(negedge clk);
      guard++;
    end
    n_vec++;
    if (guard >= INH + 100) begin
      n_miss++;
      $display("FAIL rts_wait: got no request-to-send, expected one within %0d cycles", INH + 100);
      return;
    end
    start_low = (ps2_data === 1'b0);
    for (int e = 1; e <= n_edges; e++) begin
      repeat (HALF / 2) @(negedge clk);
      if (e == FRAME_BITS) dev_data = ~ack_low;
      repeat (HALF - HALF / 2) @(negedge clk);
      dev_clk = 1'b0;
      t_fall  = $time;
      repeat (HALF) @(negedge clk);
      if (e < FRAME_BITS) seen[e-1] = ps2_data;
      dev_clk = 1'b1;
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_end(output bit got);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (done || ack_err || timeout) got = 1'b1;
    end
    repeat (3) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst            = 1'b1;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    dev_clk        = 1'b1;
    dev_data       = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_oe: got %b%b, expected 00", ps2_clk_oe, ps2_data_oe);
    end
    n_vec++;
    if (tx_if.tx_ready !== 1'b1 || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_ready_busy: got ready=%b busy=%b, expected ready=1 busy=0", tx_if.tx_ready, busy);
    end
    n_vec++;
    if ({done, ack_err, timeout} !== 3'b000) begin
      n_miss++;
      $display("FAIL reset_pulses: got %b, expected 000", {done, ack_err, timeout});
    end
    n_vec++;
    if (state_dbg !== ST_IDLE) begin
      n_miss++;
      $display("FAIL reset_state: got %0d, expected %0d", state_dbg, ST_IDLE);
    end
  endtask

  task automatic test_ed();
    logic [9:0] seen;
    bit start_low;
    bit got;
    time tf;
    int d0, n0;
    d0 = done_seen;
    n0 = nack_seen;
    send_start(8'hED);
    n_vec++;
    if (busy !== 1'b1 || tx_if.tx_ready !== 1'b0 || ps2_clk_oe !== 1'b1) begin
      n_miss++;
      $display("FAIL ed_accept: got busy=%b ready=%b clk_oe=%b, expected 1 0 1", busy, tx_if.tx_ready, ps2_clk_oe);
    end
    device_clock(FRAME_BITS, 1'b1, seen, start_low, tf);
    wait_end(got);
    n_vec++;
    if (start_low !== 1'b1) begin
      n_miss++;
      $display("FAIL ed_start: got start_low=%b, expected 1", start_low);
    end
    // data LSB first 1,0,1,1,0,1,1,1 then parity 1, stop 1
    n_vec++;
    if (seen !== 10'b11_1110_1101) begin
      n_miss++;
      $display("FAIL ed_bits: got %b, expected 1111101101", seen);
    end
    n_vec++;
    if (!got || done_seen - d0 !== 1 || nack_seen - n0 !== 0) begin
      n_miss++;
      $display("FAIL ed_done: got done=%0d ack_err=%0d, expected 1 0", done_seen - d0, nack_seen - n0);
    end
    n_vec++;
    if (inh_len !== INH) begin
      n_miss++;
      $display("FAIL ed_inhibit: got %0d cycles, expected %0d", inh_len, INH);
    end
    n_vec++;
    if (ready_at_pulse !== 1'b1) begin
      n_miss++;
      $display("FAIL ed_ready_at_pulse: got %b, expected 1", ready_at_pulse);
    end
  endtask

  task automatic test_parity();
    logic [7:0] bytes[8];
    logic [9:0] seen;
    logic [9:0] exp;
    bit start_low;
    bit got;
    time tf;
    int d0;
    bytes[0] = 8'h00;
    bytes[1] = 8'h01;
    for (int i = 2; i < 8; i++) bytes[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 8; i++) begin
      d0 = done_seen;
      exp_q.push_back(model_frame(bytes[i]));
      send_start(bytes[i]);
      device_clock(FRAME_BITS, 1'b1, seen, start_low, tf);
      wait_end(got);
      exp = exp_q.pop_front();
      n_vec++;
      if (seen !== exp || start_low !== 1'b1) begin
        n_miss++;
        $display("FAIL parity_frame[%0h]: got %b start_low=%b, expected %b start_low=1", bytes[i], seen, start_low, exp);
      end
      if (i < 2) begin
        n_vec++;
        if (seen[8] !== ((i == 0) ? 1'b1 : 1'b0)) begin
          n_miss++;
          $display("FAIL parity_bit[%0h]: got %b, expected %b", bytes[i], seen[8], (i == 0));
        end
      end
      n_vec++;
      if (!got || done_seen - d0 !== 1) begin
        n_miss++;
        $display("FAIL parity_done[%0h]: got %0d pulses, expected 1", bytes[i], done_seen - d0);
      end
    end
  endtask

  task automatic test_nack();
    logic [7:0] b;
    logic [9:0] seen;
    bit start_low;
    bit got;
    time tf;
    int d0, n0;
    b  = 8'($urandom_range(0, 255));
    d0 = done_seen;
    n0 = nack_seen;
    send_start(b);
    device_clock(FRAME_BITS, 1'b0, seen, start_low, tf);
    wait_end(got);
    n_vec++;
    if (seen !== model_frame(b)) begin
      n_miss++;
      $display("FAIL nack_frame: got %b, expected %b", seen, model_frame(b));
    end
    n_vec++;
    if (!got || nack_seen - n0 !== 1 || done_seen - d0 !== 0) begin
      n_miss++;
      $display("FAIL nack_pulse: got ack_err=%0d done=%0d, expected 1 0", nack_seen - n0, done_seen - d0);
    end
    n_vec++;
    if (ready_at_pulse !== 1'b1 || tx_if.tx_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL nack_ready: got %b/%b, expected 1/1", ready_at_pulse, tx_if.tx_ready);
    end
  endtask

  task automatic test_timeout();
    logic [9:0] seen;
    bit start_low;
    bit got;
    time tf;
    time tp;
    int d0, n0;
    d0  = done_seen;
    n0  = nack_seen;
    got = 1'b0;
    tp  = 0;
    send_start(8'($urandom_range(0, 255)));
    device_clock(4, 1'b1, seen, start_low, tf);
    for (int i = 0; i < TMO + 100 && !got; i++) begin
      @(negedge clk);
      if (timeout) begin
        got = 1'b1;
        tp  = $time;
      end
    end
    // Pad fall -> 3 cycles to the synchronized fall, then TMO idle cycles, then the pulse edge.
    n_vec++;
    if (!got || int'((tp - tf) / PERIOD) !== TMO + 4) begin
      n_miss++;
      $display("FAIL timeout_delay: got %0d cycles (seen=%b), expected %0d", int'((tp - tf) / PERIOD), got, TMO + 4);
    end
    n_vec++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL timeout_release: got clk_oe=%b data_oe=%b busy=%b, expected 000", ps2_clk_oe, ps2_data_oe, busy);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (done_seen - d0 !== 0 || nack_seen - n0 !== 0) begin
      n_miss++;
      $display("FAIL timeout_other_pulse: got done=%0d ack_err=%0d, expected 0 0", done_seen - d0, nack_seen - n0);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] seen;
    bit start_low;
    time tf;
    int d0, n0, t0;
    d0 = done_seen;
    n0 = nack_seen;
    t0 = tmo_seen;
    send_start(8'($urandom_range(0, 255)));
    device_clock(5, 1'b1, seen, start_low, tf);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL rst_mid_release: got clk_oe=%b data_oe=%b busy=%b, expected 000", ps2_clk_oe, ps2_data_oe, busy);
    end
    rst = 1'b0;
    repeat (60) @(negedge clk);
    n_vec++;
    if (done_seen != d0 || nack_seen != n0 || tmo_seen != t0) begin
      n_miss++;
      $display("FAIL rst_mid_pulses: got %0d/%0d/%0d, expected 0/0/0", done_seen - d0, nack_seen - n0, tmo_seen - t0);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] seen;
    bit start_low;
    bit got;
    time tf;
    int d0, busy_cycles;
    d0 = done_seen;
    @(negedge clk);
    tx_if.tx_data  = 8'hFF;
    tx_if.tx_valid = 1'b1;
    @(negedge clk);
    tx_if.tx_data = 8'hF4;
    device_clock(FRAME_BITS, 1'b1, seen, start_low, tf);
    n_vec++;
    if (seen !== model_frame(8'hFF)) begin
      n_miss++;
      $display("FAIL b2b_frame1: got %b, expected %b", seen, model_frame(8'hFF));
    end
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    n_vec++;
    if (!got || tx_if.tx_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL b2b_done1: got done=%b ready=%b, expected 1 1", got, tx_if.tx_ready);
    end
    @(negedge clk);
    n_vec++;
    if (ps2_clk_oe !== 1'b1 || busy !== 1'b1) begin
      n_miss++;
      $display("FAIL b2b_restart: got clk_oe=%b busy=%b, expected 1 1", ps2_clk_oe, busy);
    end
    tx_if.tx_valid = 1'b0;
    device_clock(FRAME_BITS, 1'b1, seen, start_low, tf);
    wait_end(got);
    n_vec++;
    if (seen !== model_frame(8'hF4)) begin
      n_miss++;
      $display("FAIL b2b_frame2: got %b, expected %b", seen, model_frame(8'hF4));
    end
    n_vec++;
    if (done_seen - d0 !== 2 || inh_len !== INH) begin
      n_miss++;
      $display("FAIL b2b_count: got done=%0d inhibit=%0d, expected 2 %0d", done_seen - d0, inh_len, INH);
    end
    busy_cycles = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    n_vec++;
    if (busy_cycles !== 0) begin
      n_miss++;
      $display("FAIL b2b_no_third: got %0d busy cycles, expected 0", busy_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_ed();
    test_parity();
    test_nack();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte, for example `0xED` (set LEDs) or `0xFF` (reset), from the FPGA to the keyboard over the same open-drain `ps2_clk`/`ps2_data` pair the keyboard receiver listens on. It performs the inhibit/request-to-send sequence, shifts data, parity and stop bits on device-generated clock edges, and checks the device acknowledge. `busy` tells the receiver to ignore line activity while a host frame is in progress.

## Interface
- `INHIBIT_CYCLES`, 5000: number of `clk` cycles `ps2_clk` is held low before request-to-send (≥100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, 1_000_000: maximum number of `clk` cycles between device falling edges before the frame is aborted.
- `clk`  in  1  system clock; all logic runs on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tx_data`  in  8  command byte to send.
- `tx_valid`  in  1  request; the byte is accepted when `tx_valid & tx_ready`.
- `tx_ready`  out  1  high only in IDLE.
- `ps2_clk`, `ps2_data`  in  1 each  raw pad levels (asynchronous).
- `ps2_clk_oe`, `ps2_data_oe`  out  1 each  1 = pull the line low; 0 = release it.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse: frame complete and acknowledged.
- `ack_err`  out  1  one-cycle pulse: device did not acknowledge.
- `timeout`  out  1  one-cycle pulse: frame aborted.

## Operation
- Pad inputs pass through a 2-flop synchronizer. `fall` means the previous synchronized `ps2_clk` was 1 and the current one is 0.
- Parity is odd: `par = ~^tx_data`. The shift register is loaded with `{1'b1 stop, par, tx_data}`.
- States:
  - IDLE: both `*_oe` = 0. On accept, latch the byte, clear the cycle counter, go to INHIBIT.
  - INHIBIT: `ps2_clk_oe` = 1. On the last cycle (count == `INHIBIT_CYCLES-1`) also set `ps2_data_oe` = 1 (start bit), then go to RTS.
  - RTS: `ps2_clk_oe` = 0, `ps2_data_oe` = 1. On `fall`, drive bit 0 and go to SHIFT with `bitcnt` = 1.
  - SHIFT: on each `fall`, set `ps2_data_oe` = ~shift[bitcnt] and increment `bitcnt`. Edges 1–8 carry data LSB first, edge 9 carries parity, edge 10 carries stop (line released). After edge 10, go to ACK.
  - ACK: on `fall` (edge 11), sample the synchronized `ps2_data`. 0 → go to WAIT_IDLE with ack_ok = 1. 1 → go to WAIT_IDLE with ack_ok = 0.
  - WAIT_IDLE: wait until synchronized `ps2_clk` and `ps2_data` are both 1. Then pulse `done` (ack_ok) or `ack_err` (!ack_ok) and go to IDLE.
- Timeout: in RTS, SHIFT, ACK and WAIT_IDLE, a counter clears on every `fall` and increments otherwise. When it reaches `TIMEOUT_CYCLES`, release both lines, pulse `timeout` and go to IDLE. The timeout takes priority over a `fall` in the same cycle.
- `tx_valid` is ignored while busy; there is no queue.

## Timing
- Reset values: IDLE, `ps2_clk_oe` = `ps2_data_oe` = 0, `tx_ready` = 1, `busy` = 0, `done` = `ack_err` = `timeout` = 0, all counters 0.
- Reset asserted mid-frame: both lines are released on the next clock edge and no pulse is emitted.
- Accept at edge N: `tx_ready` = 0, `busy` = 1 and `ps2_clk_oe` = 1 from edge N+1.
- Both `*_oe` outputs are registered. Data changes one `clk` after the synchronized `fall`, which is 3 `clk` cycles after the pad edge. This is well inside the device's clock-low half period.
- Pulse outputs are high for exactly one cycle. `tx_ready` returns to 1 in the same cycle as the pulse.
- Back-to-back frames: `tx_valid` held high is accepted again in the first cycle after the pulse.

## Structure
- Shared package `ps2_pkg`: state encoding (IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE), frame length constant (11), default `INHIBIT_CYCLES`/`TIMEOUT_CYCLES`.
- Sub-module `ps2_sync_edge`: 2-flop synchronizer plus falling-edge pulse. The receiver should use the same module.
- FSM, shift register, `bitcnt` (4 bits) and one shared cycle counter (20 bits) stay in `ps2_host_tx`.

## Test plan
- Send `0xED` with a device model clocking at 12 kHz and acking → line bits after start: 1,0,1,1,0,1,1,1, parity 1, stop 1. `done` pulses once; `ps2_clk_oe` held low for exactly 5000 cycles.
- Send `0x00` → parity bit 1. Send `0x01` → parity bit 0. Both frames complete with `done`.
- Device leaves data high at edge 11 → `ack_err` pulses, no `done`, `tx_ready` returns to 1.
- Device stops clocking after edge 4 → `timeout` pulses 1_000_000 cycles after the last `fall`; both `*_oe` = 0.
- Assert `rst` for one cycle during SHIFT → next cycle both `*_oe` = 0, `busy` = 0, no pulses.
- `tx_valid` held high with `0xFF` then `0xF4` → two complete frames. The second INHIBIT starts the cycle after the first `done`; `tx_valid` is ignored while busy.
